// File: rtl/imem_boot_fetch.sv
// Instruction memory with a registered fetch port (1-cycle latency) and a
// boot-load write port. A two-state FSM (LOAD/RUN) makes the two ports
// mutually exclusive, so a read and a write never hit the same cycle.
// Bad fetch addresses are reported on instr_fault and return a NOP (0);
// they are never wrapped into the array.
module imem_boot_fetch #(
  parameter int    IMEM_WIDTH    = 32,
  parameter int    IMEM_DEPTH    = 256,
  parameter string INIT_FILE     = "",
  parameter bit    BOOT_ON_RESET = 1'b1,
  localparam int   AW            = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_addr,
  output logic                  fetch_ready,
  output logic                  instr_valid,
  output logic [IMEM_WIDTH-1:0] instr,
  output logic [1:0]            instr_fault,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [AW-1:0]         load_addr,
  input  logic [IMEM_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_err,
  output logic                  boot_done
);

  typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IMEM_WIDTH-1:0] r_mem [IMEM_DEPTH];
  logic                  r_instr_valid;
  logic [IMEM_WIDTH-1:0] r_instr;
  logic [1:0]            r_fault;
  logic                  r_load_err;

  logic                  w_fetch_acc;
  logic                  w_load_acc;
  logic                  w_load_in_range;
  logic [29:0]           w_widx;
  logic [AW-1:0]         w_ridx;
  logic [1:0]            w_fault;

  assign w_fetch_acc     = fetch_req  && (r_state == S_RUN);
  assign w_load_acc      = load_valid && (r_state == S_LOAD);
  assign w_load_in_range = (32'(load_addr) < 32'(IMEM_DEPTH));

  // Word index is checked on all 30 bits so huge PCs fault instead of aliasing.
  assign w_widx     = fetch_addr[31:2];
  assign w_ridx     = w_widx[AW-1:0];
  assign w_fault[0] = (fetch_addr[1:0] != 2'b00);
  assign w_fault[1] = ({2'b00, w_widx} >= 32'(IMEM_DEPTH));

  // State register; reset picks the boot mode.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) r_state <= BOOT_ON_RESET ? S_LOAD : S_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next state and handshake outputs; load_last only counts on an accepted beat.
  always_comb begin
    w_state_nxt = r_state;
    fetch_ready = 1'b0;
    load_ready  = 1'b0;
    boot_done   = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        load_ready = 1'b1;
        if (w_load_acc && load_last) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        fetch_ready = 1'b1;
        boot_done   = 1'b1;
        if (load_start) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = r_state;
    endcase
  end

  // Array write; contents deliberately survive reset. Out-of-range beats are dropped.
  always_ff @(posedge CLK) begin
    if (w_load_acc && w_load_in_range) r_mem[load_addr] <= load_data;
  end

  // Sticky out-of-range load flag, cleared when a new load session starts.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)                              r_load_err <= 1'b0;
    else if (r_state == S_RUN && load_start) r_load_err <= 1'b0;
    else if (w_load_acc && !w_load_in_range) r_load_err <= 1'b1;
  end

  // Fetch response register; data/fault hold between accepted fetches.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_fault       <= 2'b00;
    end else begin
      r_instr_valid <= w_fetch_acc;
      if (w_fetch_acc) begin
        r_fault <= w_fault;
        r_instr <= (w_fault != 2'b00) ? '0 : r_mem[w_ridx];
      end
    end
  end

  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_fault = r_fault;
  assign load_err    = r_load_err;

endmodule

// File: tb/tb_imem_boot_fetch.sv
// Bench for imem_boot_fetch (IMEM_DEPTH=100): directed vector table, hand
// sequences for reset-in-flight cases, then random traffic against a model.
module tb_imem_boot_fetch;
  localparam int D = 100;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [1:0]  instr_fault;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [6:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        load_err;
  logic        boot_done;

  int checks = 0;
  int errors = 0;

  imem_boot_fetch #(.IMEM_WIDTH(32), .IMEM_DEPTH(D), .INIT_FILE(""), .BOOT_ON_RESET(1'b1)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instr_valid(instr_valid), .instr(instr), .instr_fault(instr_fault),
    .load_start(load_start), .load_valid(load_valid), .load_addr(load_addr),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .load_err(load_err), .boot_done(boot_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic req, input logic [31:0] fa, input logic ls,
                       input logic lv, input logic [6:0] la, input logic [31:0] ld,
                       input logic ll);
    fetch_req = req; fetch_addr = fa; load_start = ls;
    load_valid = lv; load_addr = la; load_data = ld; load_last = ll;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Directed vectors: inputs applied for one cycle, outputs checked after the edge.
  typedef struct {
    logic        req;
    logic [31:0] fa;
    logic        ls, lv;
    logic [6:0]  la;
    logic [31:0] ld;
    logic        ll;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [1:0]  e_fault;
    logic        e_run;
    logic        e_err;
  } vec_t;

  vec_t vt[20];

  // Behavioural reference: memory array, mode flag, sticky error, held response.
  logic [31:0] m_mem[D];
  bit          m_run;
  bit          m_err;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [1:0]  m_fault;

  task automatic check_all(input string tag);
    chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(m_valid));
    chk({tag, ".instr"},       instr,            m_instr);
    chk({tag, ".instr_fault"}, 32'(instr_fault), 32'(m_fault));
    chk({tag, ".fetch_ready"}, 32'(fetch_ready), 32'(m_run));
    chk({tag, ".load_ready"},  32'(load_ready),  32'(!m_run));
    chk({tag, ".boot_done"},   32'(boot_done),   32'(m_run));
    chk({tag, ".load_err"},    32'(load_err),    32'(m_err));
  endtask

  task automatic rcycle(input logic req, input logic [31:0] fa, input logic ls,
                        input logic lv, input logic [6:0] la, input logic [31:0] ld,
                        input logic ll);
    bit nxt_run;
    longint unsigned widx;
    drive(req, fa, ls, lv, la, ld, ll);
    nxt_run = m_run;
    m_valid = 1'b0;
    if (m_run) begin
      if (req) begin
        widx    = longint'(fa) / 4;
        m_valid = 1'b1;
        m_fault = {widx >= D, (fa % 4) != 0};
        m_instr = (m_fault != 2'b00) ? 32'h0 : m_mem[int'(widx)];
      end
      if (ls) begin nxt_run = 1'b0; m_err = 1'b0; end
    end else if (lv) begin
      if (int'(la) < D) m_mem[la] = ld;
      else              m_err = 1'b1;
      if (ll) nxt_run = 1'b1;
    end
    tick();
    m_run = nxt_run;
    check_all("rand");
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_err = 1'b0; m_valid = 1'b0; m_instr = '0; m_fault = 2'b00;
  endtask

  initial begin
    logic [31:0] fa;
    logic [31:0] pick;

    //           req fa          ls lv la  ld            ll   valid instr         flt  run err
    vt[0]  = '{0, 32'h0,   0, 1, 0,  32'h20080005, 0,   0, 32'h0,        2'b00, 0, 0};
    vt[1]  = '{0, 32'h0,   0, 1, 1,  32'h20090003, 0,   0, 32'h0,        2'b00, 0, 0};
    vt[2]  = '{0, 32'h0,   0, 1, 2,  32'h01095020, 0,   0, 32'h0,        2'b00, 0, 0};
    vt[3]  = '{0, 32'h0,   0, 1, 3,  32'hAC0A0000, 1,   0, 32'h0,        2'b00, 1, 0};
    vt[4]  = '{1, 32'h0,   0, 0, 0,  32'h0,        0,   1, 32'h20080005, 2'b00, 1, 0};
    vt[5]  = '{1, 32'h4,   0, 0, 0,  32'h0,        0,   1, 32'h20090003, 2'b00, 1, 0};
    vt[6]  = '{1, 32'h8,   0, 0, 0,  32'h0,        0,   1, 32'h01095020, 2'b00, 1, 0};
    vt[7]  = '{1, 32'hC,   0, 0, 0,  32'h0,        0,   1, 32'hAC0A0000, 2'b00, 1, 0};
    vt[8]  = '{1, 32'h6,   0, 0, 0,  32'h0,        0,   1, 32'h0,        2'b01, 1, 0};
    vt[9]  = '{1, 32'd400, 0, 0, 0,  32'h0,        0,   1, 32'h0,        2'b10, 1, 0};
    vt[10] = '{1, 32'd402, 0, 0, 0,  32'h0,        0,   1, 32'h0,        2'b11, 1, 0};
    vt[11] = '{0, 32'h0,   0, 0, 0,  32'h0,        0,   0, 32'h0,        2'b11, 1, 0};
    vt[12] = '{0, 32'h0,   0, 1, 0,  32'hFFFFFFFF, 1,   0, 32'h0,        2'b11, 1, 0};
    vt[13] = '{1, 32'h0,   0, 0, 0,  32'h0,        0,   1, 32'h20080005, 2'b00, 1, 0};
    vt[14] = '{1, 32'h4,   1, 0, 0,  32'h0,        0,   1, 32'h20090003, 2'b00, 0, 0};
    vt[15] = '{0, 32'h0,   0, 0, 0,  32'h0,        0,   0, 32'h20090003, 2'b00, 0, 0};
    vt[16] = '{0, 32'h0,   0, 1, 120, 32'hDEADBEEF, 0,  0, 32'h20090003, 2'b00, 0, 1};
    vt[17] = '{0, 32'h0,   0, 1, 5,  32'h12345678, 1,   0, 32'h20090003, 2'b00, 1, 1};
    vt[18] = '{1, 32'h14,  0, 0, 0,  32'h0,        0,   1, 32'h12345678, 2'b00, 1, 1};
    vt[19] = '{0, 32'h0,   1, 0, 0,  32'h0,        0,   0, 32'h12345678, 2'b00, 0, 0};

    // Reset state, checked while reset is held.
    #1;
    chk("rst.instr_valid", 32'(instr_valid), 32'h0);
    chk("rst.instr",       instr,            32'h0);
    chk("rst.instr_fault", 32'(instr_fault), 32'h0);
    chk("rst.load_ready",  32'(load_ready),  32'h1);
    chk("rst.fetch_ready", 32'(fetch_ready), 32'h0);
    chk("rst.boot_done",   32'(boot_done),   32'h0);
    chk("rst.load_err",    32'(load_err),    32'h0);
    #11 RST_n = 1'b1;
    tick();

    for (int i = 0; i < 20; i++) begin
      drive(vt[i].req, vt[i].fa, vt[i].ls, vt[i].lv, vt[i].la, vt[i].ld, vt[i].ll);
      tick();
      chk($sformatf("vec%0d.instr_valid", i), 32'(instr_valid), 32'(vt[i].e_valid));
      chk($sformatf("vec%0d.instr", i),       instr,            vt[i].e_instr);
      chk($sformatf("vec%0d.instr_fault", i), 32'(instr_fault), 32'(vt[i].e_fault));
      chk($sformatf("vec%0d.fetch_ready", i), 32'(fetch_ready), 32'(vt[i].e_run));
      chk($sformatf("vec%0d.load_ready", i),  32'(load_ready),  32'(!vt[i].e_run));
      chk($sformatf("vec%0d.boot_done", i),   32'(boot_done),   32'(vt[i].e_run));
      chk($sformatf("vec%0d.load_err", i),    32'(load_err),    32'(vt[i].e_err));
    end

    // Reset between load beats: already-written words survive.
    drive(0, 0, 0, 1, 10, 32'hCAFEF00D, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 RST_n = 1'b0;
    #1;
    chk("midload.load_ready",  32'(load_ready),  32'h1);
    chk("midload.boot_done",   32'(boot_done),   32'h0);
    chk("midload.instr_valid", 32'(instr_valid), 32'h0);
    #2 RST_n = 1'b1;
    tick();
    drive(0, 0, 0, 1, 11, 32'h0BADBEEF, 1);
    tick();
    chk("midload.boot_done2", 32'(boot_done), 32'h1);
    drive(1, 32'h28, 0, 0, 0, 0, 0);
    tick();
    chk("kept.valid", 32'(instr_valid), 32'h1);
    chk("kept.instr", instr, 32'hCAFEF00D);
    // Reset with a response on the output: cancelled without waiting for a clock.
    drive(0, 0, 0, 0, 0, 0, 0);
    RST_n = 1'b0;
    #1;
    chk("cancel.instr_valid", 32'(instr_valid), 32'h0);
    chk("cancel.instr",       instr,            32'h0);
    chk("cancel.load_ready",  32'(load_ready),  32'h1);
    #2 RST_n = 1'b1;
    tick();
    drive(0, 0, 0, 1, 12, 32'h0, 1);
    tick();
    drive(1, 32'h2C, 0, 0, 0, 0, 0);
    tick();
    chk("kept2.instr", instr, 32'h0BADBEEF);
    drive(1, 32'h0, 0, 0, 0, 0, 0);
    tick();
    chk("kept3.instr", instr, 32'h20080005);

    // Random traffic against the model, starting from a fresh reset and full load.
    drive(0, 0, 0, 0, 0, 0, 0);
    RST_n = 1'b0;
    #3 RST_n = 1'b1;
    model_reset();
    tick();
    check_all("rrst");
    for (int i = 0; i < D; i++) rcycle(0, 0, 0, 1, 7'(i), $urandom, i == D - 1);
    for (int i = 0; i < 3000; i++) begin
      pick = $urandom_range(0, 7);
      if (pick == 0)      fa = $urandom;
      else if (pick == 1) fa = (D + $urandom_range(0, 20)) * 4 + $urandom_range(0, 3);
      else                fa = $urandom_range(0, D - 1) * 4 +
                               (($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0);
      rcycle($urandom_range(0, 9) < 7, fa, $urandom_range(0, 15) == 0,
             $urandom_range(0, 1) == 1, 7'($urandom_range(0, 127)), $urandom,
             $urandom_range(0, 5) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
